// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with a two-entry skid buffer.
// in_ready is registered, so no combinational ready path runs through this stage.
module mem_wb_skid_stage #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int SEL_W     = 1,
  parameter int ZERO_KILL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_mem_data,
  input  logic [XLEN-1:0]   in_ex_result,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_werf,
  input  logic [SEL_W-1:0]  in_wb_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_mem_data,
  output logic [XLEN-1:0]   out_ex_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_werf,
  output logic [SEL_W-1:0]  out_wb_sel,
  output logic [1:0]        occupancy
);

  localparam int PW = 2*XLEN + REG_AW + 1 + SEL_W;

  // State encoding doubles as the beat count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_in_ready;
  logic [PW-1:0] r_main;
  logic [PW-1:0] r_skid;
  logic [PW-1:0] w_in;
  logic          w_accept;
  logic          w_pop;
  logic          w_ld_main_in;
  logic          w_ld_main_skid;
  logic          w_ld_skid;
  logic          w_werf;
  logic          w_kill;

  assign w_in     = {in_mem_data, in_ex_result,
                     in_rd, in_werf, in_wb_sel};
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_ld_main_in = 1'b1;
            w_state_nxt  = S_ONE;
          end
        end
        S_ONE: begin
          if (w_pop && w_accept) begin
            w_ld_main_in = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = S_EMPTY;
          end else if (w_accept) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = S_TWO;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            w_ld_main_skid = 1'b1;
            w_state_nxt    = S_ONE;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
    end
  end

  // Payload is left untouched on flush; out_valid gates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
    end else if (w_ld_main_in) begin
      r_main <= w_in;
    end else if (w_ld_main_skid) begin
      r_main <= r_skid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid <= '0;
    end else if (w_ld_skid) begin
      r_skid <= w_in;
    end
  end

  assign {out_mem_data, out_ex_result,
          out_rd, w_werf, out_wb_sel} = r_main;

  assign w_kill    = (ZERO_KILL != 0) && (out_rd == '0);
  assign out_werf  = out_valid & w_werf & ~w_kill;
  assign in_ready  = r_in_ready;
  assign occupancy = r_state;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Randomized and directed bench for mem_wb_skid_stage.
// A queue-based reference model tracks held beats and the ready flag.
module tb_mem_wb_skid_stage;

  typedef struct {
    logic [31:0] md;
    logic [31:0] ex;
    logic [4:0]  rd;
    logic        werf;
    logic        sel;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_mem_data, in_ex_result;
  logic [4:0]  in_rd;
  logic        in_werf, in_wb_sel;

  logic        in_ready, out_valid, out_werf, out_wb_sel;
  logic [31:0] out_mem_data, out_ex_result;
  logic [4:0]  out_rd;
  logic [1:0]  occupancy;

  logic        z_in_ready, z_out_valid, z_out_werf, z_out_wb_sel;
  logic [31:0] z_out_mem_data, z_out_ex_result;
  logic [4:0]  z_out_rd;
  logic [1:0]  z_occupancy;

  int    n_pass = 0;
  int    n_total = 0;
  beat_t q[$];
  logic  m_ready = 1'b0;

  always #5 clk = ~clk;

  mem_wb_skid_stage #(.ZERO_KILL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_data(in_mem_data), .in_ex_result(in_ex_result),
    .in_rd(in_rd), .in_werf(in_werf), .in_wb_sel(in_wb_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mem_data(out_mem_data), .out_ex_result(out_ex_result),
    .out_rd(out_rd), .out_werf(out_werf), .out_wb_sel(out_wb_sel),
    .occupancy(occupancy)
  );

  mem_wb_skid_stage #(.ZERO_KILL(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready),
    .in_mem_data(in_mem_data), .in_ex_result(in_ex_result),
    .in_rd(in_rd), .in_werf(in_werf), .in_wb_sel(in_wb_sel),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .out_mem_data(z_out_mem_data), .out_ex_result(z_out_ex_result),
    .out_rd(z_out_rd), .out_werf(z_out_werf), .out_wb_sel(z_out_wb_sel),
    .occupancy(z_occupancy)
  );

  task automatic drive(input logic v, input logic [31:0] md,
                       input logic [31:0] ex, input logic [4:0] rd,
                       input logic we, input logic sel);
    in_valid = v; in_mem_data = md; in_ex_result = ex;
    in_rd = rd; in_werf = we; in_wb_sel = sel;
  endtask

  // Advance one clock: the model applies the sampled inputs, then wait to the falling edge.
  task automatic tick();
    bit    do_pop, do_acc;
    beat_t b;
    @(posedge clk);
    b.md = in_mem_data; b.ex = in_ex_result; b.rd = in_rd;
    b.werf = in_werf; b.sel = in_wb_sel;
    if (rst) begin
      q.delete(); m_ready = 1'b0;
    end else if (flush) begin
      q.delete(); m_ready = 1'b1;
    end else begin
      do_pop = (q.size() > 0) && out_ready;
      do_acc = in_valid && m_ready;
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back(b);
      m_ready = (q.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", in_ready); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL rst_occ got %0d want 0", occupancy); else n_pass++;
    n_total++; if (out_werf !== 1'b0) $display("FAIL rst_werf got %0b want 0", out_werf); else n_pass++;
    n_total++; if ({out_mem_data, out_ex_result, out_rd, out_wb_sel} !== '0)
      $display("FAIL rst_payload got %h/%h/%0d/%0b want 0", out_mem_data, out_ex_result, out_rd, out_wb_sel);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL rel_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL rel_occ got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] want;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      want = 32'h10 + i;
      drive(1'b1, $urandom, want, 5'($urandom), 1'($urandom), 1'($urandom));
      tick();
      n_total++; if (out_ex_result !== want) $display("FAIL stream_ex%0d got %h want %h", i, out_ex_result, want); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL stream_valid%0d got %0b want 1", i, out_valid); else n_pass++;
      n_total++; if (occupancy !== 2'd1) $display("FAIL stream_occ%0d got %0d want 1", i, occupancy); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL stream_ready%0d got %0b want 1", i, in_ready); else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 32'hAAAA0001, 5'd1, 1'b1, 1'b0);
    tick();
    n_total++; if (out_ex_result !== 32'hAAAA0001) $display("FAIL bp_a got %h want aaaa0001", out_ex_result); else n_pass++;
    drive(1'b1, 32'h2, 32'hBBBB0002, 5'd2, 1'b1, 1'b1);
    tick();
    n_total++; if (occupancy !== 2'd2) $display("FAIL bp_occ2 got %0d want 2", occupancy); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready0 got %0b want 0", in_ready); else n_pass++;
    n_total++; if (out_ex_result !== 32'hAAAA0001) $display("FAIL bp_hold got %h want aaaa0001", out_ex_result); else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_ex_result !== 32'hBBBB0002) $display("FAIL bp_b got %h want bbbb0002", out_ex_result); else n_pass++;
    n_total++; if (out_wb_sel !== 1'b1) $display("FAIL bp_b_sel got %0b want 1", out_wb_sel); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready1 got %0b want 1", in_ready); else n_pass++;
    n_total++; if (occupancy !== 2'd1) $display("FAIL bp_occ1 got %0d want 1", occupancy); else n_pass++;
    tick();
    n_total++; if (occupancy !== 2'd0) $display("FAIL bp_occ0 got %0d want 0", occupancy); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h5, 32'h55, 5'd7, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h6, 32'h66, 5'd8, 1'b1, 1'b0); tick();
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h7, 32'h77, 5'd9, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL fl_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_werf !== 1'b0) $display("FAIL fl_werf got %0b want 0", out_werf); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL fl_occ got %0d want 0", occupancy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL fl_ready got %0b want 1", in_ready); else n_pass++;
    drive(1'b1, 32'h0000CCCC, 32'h0000CCCC, 5'd3, 1'b1, 1'b0);
    tick();
    n_total++; if (out_ex_result !== 32'h0000CCCC) $display("FAIL fl_c got %h want 0000cccc", out_ex_result); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL fl_c_valid got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_werf !== 1'b1) $display("FAIL fl_c_werf got %0b want 1", out_werf); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_zero_kill();
    out_ready = 1'b1;
    drive(1'b1, $urandom, $urandom, 5'd0, 1'b1, 1'b0);
    tick();
    n_total++; if (out_werf !== 1'b0) $display("FAIL zk1_rd0 got %0b want 0", out_werf); else n_pass++;
    n_total++; if (z_out_werf !== 1'b1) $display("FAIL zk0_rd0 got %0b want 1", z_out_werf); else n_pass++;
    drive(1'b1, $urandom, $urandom, 5'd5, 1'b1, 1'b0);
    tick();
    n_total++; if (out_werf !== 1'b1) $display("FAIL zk1_rd5 got %0b want 1", out_werf); else n_pass++;
    n_total++; if (z_out_werf !== 1'b1) $display("FAIL zk0_rd5 got %0b want 1", z_out_werf); else n_pass++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic e_v, e_w1, e_w0;
    beat_t h;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
      e_v  = (q.size() > 0);
      e_w1 = 1'b0; e_w0 = 1'b0;
      if (e_v) begin
        h = q[0];
        e_w0 = h.werf;
        e_w1 = h.werf && (h.rd != 5'd0);
      end
      n_total++; if (out_valid !== e_v) $display("FAIL rnd_valid c%0d got %0b want %0b", c, out_valid, e_v); else n_pass++;
      n_total++; if (occupancy !== 2'(q.size())) $display("FAIL rnd_occ c%0d got %0d want %0d", c, occupancy, q.size()); else n_pass++;
      n_total++; if (in_ready !== m_ready) $display("FAIL rnd_ready c%0d got %0b want %0b", c, in_ready, m_ready); else n_pass++;
      n_total++; if (out_werf !== e_w1) $display("FAIL rnd_werf c%0d got %0b want %0b", c, out_werf, e_w1); else n_pass++;
      n_total++; if (z_out_werf !== e_w0) $display("FAIL rnd_werf0 c%0d got %0b want %0b", c, z_out_werf, e_w0); else n_pass++;
      n_total++; if ({z_out_valid, z_occupancy, z_in_ready} !== {e_v, 2'(q.size()), m_ready})
        $display("FAIL rnd_ctl0 c%0d got %0b%0d%0b want %0b%0d%0b", c, z_out_valid, z_occupancy, z_in_ready, e_v, q.size(), m_ready);
      else n_pass++;
      if (e_v) begin
        n_total++;
        if ({out_mem_data, out_ex_result, out_rd, out_wb_sel} !== {h.md, h.ex, h.rd, h.sel} ||
            {z_out_mem_data, z_out_ex_result, z_out_rd, z_out_wb_sel} !== {h.md, h.ex, h.rd, h.sel})
          $display("FAIL rnd_beat c%0d got %h/%h/%0d/%0b want %h/%h/%0d/%0b", c,
                   out_mem_data, out_ex_result, out_rd, out_wb_sel, h.md, h.ex, h.rd, h.sel);
        else n_pass++;
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h9, 32'h99, 5'd4, 1'b1, 1'b1); tick();
    drive(1'b1, 32'hA, 32'hAA, 5'd6, 1'b1, 1'b1); tick();
    n_total++; if (occupancy !== 2'd2) $display("FAIL ar_setup got %0d want 2", occupancy); else n_pass++;
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    q.delete(); m_ready = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL ar_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_werf !== 1'b0) $display("FAIL ar_werf got %0b want 0", out_werf); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL ar_occ got %0d want 0", occupancy); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL ar_ready got %0b want 0", in_ready); else n_pass++;
    n_total++; if ({out_mem_data, out_ex_result, out_rd, out_wb_sel} !== '0)
      $display("FAIL ar_payload got %h/%h/%0d/%0b want 0", out_mem_data, out_ex_result, out_rd, out_wb_sel);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL ar_rel_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL ar_stale1 got %0b want 0", out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL ar_stale2 got %0b/%0d want 0/0", out_valid, occupancy);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_zero_kill();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
